// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter: data width,
// default line geometry, starvation limits and FSM state encodings.
package mem_port_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int MAX_WAIT_DEF   = 4;
  localparam int WAIT_W_DEF     = 3;
  localparam int IDX_W_DEF      = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IREFILL = 2'd1,
    ARB_DACCESS = 2'd2
  } arb_state_e;

  // Byte-offset width of one icache line (word index bits + 2 byte bits).
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of icache refill, data access and external memory port signals.
// The arbiter connects through the master modport; the environment uses slave.
interface mem_port_arbiter_if #(
  parameter int XLEN   = mem_port_arbiter_pkg::XLEN,
  parameter int IDX_W  = mem_port_arbiter_pkg::IDX_W_DEF,
  parameter int WAIT_W = mem_port_arbiter_pkg::WAIT_W_DEF
);
  logic              ic_req;
  logic [XLEN-1:0]   ic_addr;
  logic              ic_beat_valid;
  logic [IDX_W-1:0]  ic_beat_idx;
  logic [XLEN-1:0]   ic_rdata;
  logic              ic_done;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [3:0]        d_wstrb;
  logic [XLEN-1:0]   d_rdata;
  logic              d_done;

  logic              mem_valid;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  logic [WAIT_W-1:0] ic_wait_cnt;

  modport master (
    input  ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output ic_beat_valid, ic_beat_idx, ic_rdata, ic_done, d_rdata, d_done,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, ic_wait_cnt
  );

  modport slave (
    output ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  ic_beat_valid, ic_beat_idx, ic_rdata, ic_done, d_rdata, d_done,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, ic_wait_cnt
  );
endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// Beat tracker for icache line refills: word index, last-beat flag and
// the address of the following beat.
module arb_burst_counter #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [XLEN-1:0]  cur_addr,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic [XLEN-1:0]  next_addr
);
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr)      idx_d = '0;
    else if (adv) idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idx_q <= '0;
    else          idx_q <= idx_d;
  end

  assign idx       = idx_q;
  assign last      = (idx_q == IDX_W'(LINE_WORDS - 1));
  assign next_addr = cur_addr + XLEN'(4);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache line refills (bursts) and data
// loads/stores (single beats); data has priority, bounded by a starvation count.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF,
  parameter int WAIT_W     = WAIT_W_DEF
) (
  input logic          clk,
  input logic          reset_n,
  mem_port_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = line_off_w(LINE_WORDS);

  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              ic_beat_valid_q, ic_beat_valid_d;
  logic [IDX_W-1:0]  ic_beat_idx_q, ic_beat_idx_d;
  logic [XLEN-1:0]   ic_rdata_q, ic_rdata_d;
  logic              ic_done_q, ic_done_d;
  logic              d_done_q, d_done_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              burst_clr, burst_adv, burst_last;
  logic [IDX_W-1:0]  burst_idx;
  logic [XLEN-1:0]   burst_next_addr;
  logic              starved;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.ic_addr[OFF_W-1:0], bus.d_addr[1:0]};
  assign starved          = bus.ic_req && (wait_q == WAIT_W'(MAX_WAIT));

  arb_burst_counter #(.XLEN(XLEN), .LINE_WORDS(LINE_WORDS)) u_burst (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (burst_clr),
    .adv      (burst_adv),
    .cur_addr (mem_addr_q),
    .idx      (burst_idx),
    .last     (burst_last),
    .next_addr(burst_next_addr)
  );

  always_comb begin
    state_d         = state_q;
    mem_valid_d     = mem_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    ic_beat_valid_d = 1'b0;
    ic_beat_idx_d   = ic_beat_idx_q;
    ic_rdata_d      = ic_rdata_q;
    ic_done_d       = 1'b0;
    d_done_d        = 1'b0;
    d_rdata_d       = d_rdata_q;
    wait_d          = wait_q;
    burst_clr       = 1'b0;
    burst_adv       = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (starved || (bus.ic_req && !bus.d_req)) begin
          state_d     = ARB_IREFILL;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {bus.ic_addr[XLEN-1:OFF_W], OFF_W'(0)};
          mem_wdata_d = '0;
          mem_wstrb_d = 4'h0;
          wait_d      = '0;
          burst_clr   = 1'b1;
        end else if (bus.d_req) begin
          state_d     = ARB_DACCESS;
          mem_valid_d = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = {bus.d_addr[XLEN-1:2], 2'b00};
          mem_wdata_d = bus.d_wdata;
          mem_wstrb_d = bus.d_we ? bus.d_wstrb : 4'h0;
          // Count only grants that actually pass over a waiting refill.
          if (bus.ic_req && (wait_q != WAIT_W'(MAX_WAIT)))
            wait_d = wait_q + WAIT_W'(1);
        end
      end

      ARB_DACCESS: begin
        if (bus.mem_ready) begin
          d_done_d    = 1'b1;
          d_rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'h0;
          state_d     = ARB_IDLE;
        end
      end

      ARB_IREFILL: begin
        if (bus.mem_ready) begin
          ic_beat_valid_d = 1'b1;
          ic_beat_idx_d   = burst_idx;
          ic_rdata_d      = bus.mem_rdata;
          burst_adv       = 1'b1;
          if (burst_last) begin
            ic_done_d   = 1'b1;
            mem_valid_d = 1'b0;
            state_d     = ARB_IDLE;
          end else begin
            mem_addr_d  = burst_next_addr;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ARB_IDLE;
      mem_valid_q     <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= 4'h0;
      ic_beat_valid_q <= 1'b0;
      ic_beat_idx_q   <= '0;
      ic_rdata_q      <= '0;
      ic_done_q       <= 1'b0;
      d_done_q        <= 1'b0;
      d_rdata_q       <= '0;
      wait_q          <= '0;
    end else begin
      state_q         <= state_d;
      mem_valid_q     <= mem_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      ic_beat_valid_q <= ic_beat_valid_d;
      ic_beat_idx_q   <= ic_beat_idx_d;
      ic_rdata_q      <= ic_rdata_d;
      ic_done_q       <= ic_done_d;
      d_done_q        <= d_done_d;
      d_rdata_q       <= d_rdata_d;
      wait_q          <= wait_d;
    end
  end

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign bus.ic_beat_valid = ic_beat_valid_q;
  assign bus.ic_beat_idx   = ic_beat_idx_q;
  assign bus.ic_rdata      = ic_rdata_q;
  assign bus.ic_done       = ic_done_q;
  assign bus.d_done        = d_done_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.ic_wait_cnt   = wait_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory beats, refill beats
// and data completions are queued with the stimulus and popped as they occur.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; logic [2:0] wcnt;} mexp_t;
  typedef struct {logic [1:0] idx; logic [31:0] data; logic last;} bexp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;} dreq_t;

  mexp_t       exp_mem[$];
  bexp_t       exp_beat[$];
  logic [31:0] exp_d[$];
  dreq_t       d_tab[$];

  int n_chk = 0, n_fail = 0, beats_seen = 0, rsp_wait = 0, mem_lat = 0;
  bit stray_rdy = 1'b0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic queue_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] wcnt);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    d_tab.push_back('{we, addr, wdata, strb});
    exp_mem.push_back('{wa, we, (we ? strb : 4'h0), wdata, wcnt});
    exp_d.push_back(we ? 32'h0 : mdata(wa));
  endtask

  task automatic queue_ic(input logic [31:0] addr, input logic [2:0] wcnt);
    logic [31:0] base, a;
    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) begin
      a = base + 32'(4 * i);
      exp_mem.push_back('{a, 1'b0, 4'h0, 32'h0, wcnt});
      exp_beat.push_back('{2'(i), mdata(a), (i == 3)});
    end
  endtask

  task automatic drive_d();
    bus.d_req   = 1'b1;
    bus.d_we    = d_tab[0].we;
    bus.d_addr  = d_tab[0].addr;
    bus.d_wdata = d_tab[0].wdata;
    bus.d_wstrb = d_tab[0].strb;
  endtask

  task automatic flush_all();
    exp_mem.delete(); exp_beat.delete(); exp_d.delete(); d_tab.delete();
  endtask

  // Runs on every falling edge: observe DUT outputs, then act as the memory.
  task automatic mon_step();
    bexp_t b;
    mexp_t m;
    if (!reset_n) begin
      bus.mem_ready = 1'b0;
      rsp_wait = 0;
      return;
    end
    if (bus.ic_beat_valid) begin
      beats_seen++;
      if (exp_beat.size() == 0) chk("beat_unexpected", 32'(exp_beat.size()), 32'd1);
      else begin
        b = exp_beat.pop_front();
        chk("beat_idx", 32'(bus.ic_beat_idx), 32'(b.idx));
        chk("beat_data", bus.ic_rdata, b.data);
        chk("ic_done", 32'(bus.ic_done), 32'(b.last));
        if (b.last) bus.ic_req = 1'b0;
      end
    end else if (bus.ic_done) chk("ic_done_stray", 32'(bus.ic_done), 32'd0);
    if (bus.d_done) begin
      if (exp_d.size() == 0) chk("d_done_unexpected", 32'(exp_d.size()), 32'd1);
      else chk("d_rdata", bus.d_rdata, exp_d.pop_front());
      if (d_tab.size() > 0) void'(d_tab.pop_front());
      if (d_tab.size() > 0) drive_d();
      else bus.d_req = 1'b0;
    end
    if (bus.mem_valid) begin
      if (rsp_wait >= mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mdata(bus.mem_addr);
        rsp_wait = 0;
        if (exp_mem.size() == 0) chk("mem_unexpected", 32'(exp_mem.size()), 32'd1);
        else begin
          m = exp_mem.pop_front();
          chk("mem_addr", bus.mem_addr, m.addr);
          chk("mem_we", 32'(bus.mem_we), 32'(m.we));
          chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m.strb));
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
          chk("ic_wait_cnt", 32'(bus.ic_wait_cnt), 32'(m.wcnt));
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_0001;
        rsp_wait++;
      end
    end else begin
      bus.mem_ready = stray_rdy;
      bus.mem_rdata = 32'hBAD0_0000;
      rsp_wait = 0;
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (n < max && ((exp_mem.size() + exp_beat.size() + exp_d.size()) != 0 || bus.d_req || bus.ic_req)) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_pending"}, 32'(exp_mem.size() + exp_beat.size() + exp_d.size()), 32'd0);
    if (n >= max) begin
      bus.d_req = 1'b0; bus.ic_req = 1'b0; flush_all();
    end
    @(negedge clk); #1;
    chk({tag, "_mv_idle"}, 32'(bus.mem_valid), 32'd0);
  endtask

  task automatic wait_beats(input string tag, input int tgt, input int max);
    int n = 0;
    while (n < max && beats_seen < tgt) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_beats"}, 32'(beats_seen >= tgt), 32'd1);
  endtask

  initial begin
    int tgt;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = 4'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    #12;
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_beat_valid", 32'(bus.ic_beat_valid), 32'd0);
    chk("rst_ic_done", 32'(bus.ic_done), 32'd0);
    chk("rst_d_done", 32'(bus.d_done), 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_wait_cnt", 32'(bus.ic_wait_cnt), 32'd0);
    @(negedge clk); #1; reset_n = 1'b1;

    // Lone load, 2-cycle memory latency, stray ready while idle.
    stray_rdy = 1'b1; mem_lat = 2;
    repeat (2) @(negedge clk); #1;
    queue_data(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'd0);
    drive_d();
    wait_idle("load", 60);

    // Lone refill, zero-wait memory; unaligned miss address.
    stray_rdy = 1'b0; mem_lat = 0;
    queue_ic(32'h0000_203C, 3'd0);
    bus.ic_addr = 32'h0000_203C; bus.ic_req = 1'b1;
    wait_idle("refill", 60);

    // Simultaneous requests: data first, then refill.
    stray_rdy = 1'b1; mem_lat = 1;
    queue_data(1'b0, 32'h0000_0042, 32'h0, 4'h0, 3'd1);
    queue_ic(32'h0000_1000, 3'd0);
    drive_d();
    bus.ic_addr = 32'h0000_1000; bus.ic_req = 1'b1;
    wait_idle("simul", 80);

    // Starvation: four data grants, forced refill, then the waiting load.
    stray_rdy = 1'b0; mem_lat = 0;
    queue_data(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'd1);
    queue_data(1'b0, 32'h0000_0084, 32'h0, 4'h0, 3'd2);
    queue_data(1'b0, 32'h0000_0088, 32'h0, 4'h0, 3'd3);
    queue_data(1'b0, 32'h0000_008C, 32'h0, 4'h0, 3'd4);
    queue_ic(32'h0000_4000, 3'd0);
    queue_data(1'b0, 32'h0000_0090, 32'h0, 4'h0, 3'd0);
    drive_d();
    bus.ic_addr = 32'h0000_4000; bus.ic_req = 1'b1;
    wait_idle("starve", 200);
    chk("starve_wait_clr", 32'(bus.ic_wait_cnt), 32'd0);

    // Store raised mid-burst waits for ic_done.
    mem_lat = 1;
    tgt = beats_seen + 2;
    queue_ic(32'h0000_3008, 3'd0);
    bus.ic_addr = 32'h0000_3008; bus.ic_req = 1'b1;
    wait_beats("store", tgt, 40);
    queue_data(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 3'd0);
    drive_d();
    wait_idle("store", 80);

    // Reset after beat 2 aborts the burst; a new refill restarts at beat 0.
    mem_lat = 0;
    tgt = beats_seen + 3;
    queue_ic(32'h0000_5000, 3'd0);
    bus.ic_addr = 32'h0000_5000; bus.ic_req = 1'b1;
    wait_beats("rst", tgt, 40);
    reset_n = 1'b0; bus.ic_req = 1'b0;
    #1;
    chk("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_beat_valid", 32'(bus.ic_beat_valid), 32'd0);
    chk("midrst_ic_rdata", bus.ic_rdata, 32'd0);
    chk("midrst_ic_done", 32'(bus.ic_done), 32'd0);
    flush_all();
    repeat (3) @(negedge clk); #1;
    reset_n = 1'b1;
    queue_ic(32'h0000_6010, 3'd0);
    bus.ic_addr = 32'h0000_6010; bus.ic_req = 1'b1;
    wait_idle("rst_restart", 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
